fetch_queue: RTL

- Instruction buffer between the fetch stage and the decode stage of the in-order RISC-V pipeline.
- Captures each fetched {pc, inst} pair into a small circular FIFO and presents the oldest entry to decode with valid/ready handshake.
- Back-pressures fetch through in_ready; fetch stalls its PC when in_ready is low.
- Discards all buffered instructions on a control-flow redirect (flush).

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue.sv | 88 ++++++++
 2 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: the buffered entry layout and default depth.
package sys_defs;

  localparam int FQ_DEPTH  = 4;
  localparam int FQ_PC_W   = 64;
  localparam int FQ_INST_W = 32;

  // One buffered instruction: PC in the upper bits, instruction word below.
  typedef struct packed {
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_INST_W-1:0] inst;
  } FQ_ENTRY;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of {pc, inst} with
// valid/ready on both sides and a flush that empties it on a redirect.
module fetch_queue
  import sys_defs::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int PC_W   = FQ_PC_W,
  parameter int INST_W = FQ_INST_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [INST_W-1:0]         in_inst,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [PC_W-1:0]           out_pc,
  output logic [INST_W-1:0]         out_inst,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = PC_W + INST_W;

  // Entries are packed {pc, inst}, the same layout as FQ_ENTRY.
  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] rptr_reg, rptr_next;
  logic [PW-1:0] wptr_reg, wptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push;
  logic          pop;
  logic          full;
  logic [EW-1:0] head;

  // Full is judged on the registered count only, so out_ready never reaches in_ready.
  always_comb begin
    full      = (count_reg == CW'(DEPTH));
    in_ready  = ~rst & ~full;
    out_valid = (count_reg != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Pointer and occupancy next-state; reset and flush both return to empty.
  always_comb begin
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    if (rst || flush) begin
      rptr_next  = '0;
      wptr_next  = '0;
      count_next = '0;
    end else begin
      if (push) wptr_next = wptr_reg + PW'(1);
      if (pop)  rptr_next = rptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State register for pointers and occupancy.
  always_ff @(posedge clk) begin
    rptr_reg  <= rptr_next;
    wptr_reg  <= wptr_next;
    count_reg <= count_next;
  end

  // Storage write; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg] <= {in_pc, in_inst};
  end

  // Head is read straight from the array and forced to zero when empty.
  always_comb begin
    head     = out_valid ? mem[rptr_reg] : '0;
    out_pc   = head[EW-1:INST_W];
    out_inst = head[INST_W-1:0];
    count    = count_reg;
  end

endmodule
